// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shift register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
   parameter int CLK_FREQ   = 12000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic       busy,
   output logic       txd
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BW = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ / BAUD must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state, state_next;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   head, tail;
   logic [CW-1:0]   count;
   logic [7:0]      shift, shift_next;
   logic [2:0]      bit_idx, bit_next;
   logic [BW-1:0]   baud_cnt, baud_next;
   logic            txd_q, txd_next;
   logic            push, pop, baud_done;
`ifdef UART_TX_PARITY_EN
   logic            parity_q, parity_next;
`endif

   // Write port: a byte moves on every edge where wr_valid && wr_ready; wr_ready
   // depends only on the registered count, so a same-cycle pop never raises it.
   assign wr_ready  = (count != FULL);
   assign push      = wr_valid && wr_ready;
   assign baud_done = (baud_cnt == BAUD_LAST);
   assign pop       = (count != '0) && ((state == IDLE) || (state == STOP && baud_done));
   assign busy      = (state != IDLE) || (count != '0);
   assign txd       = txd_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (count != '0) state_next = START;
         START: if (baud_done) state_next = DATA;
`ifdef UART_TX_PARITY_EN
         DATA:   if (baud_done && bit_idx == 3'd7) state_next = PARITY;
         PARITY: if (baud_done) state_next = STOP;
`else
         DATA:  if (baud_done && bit_idx == 3'd7) state_next = STOP;
`endif
         STOP:  if (baud_done) state_next = (count != '0) ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // txd is registered from the next-state view so the line changes right on the edge.
   always_comb begin
      shift_next = shift;
      bit_next   = bit_idx;
      baud_next  = baud_cnt;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_q;
`endif
      if (pop) begin
         shift_next = mem[head];
         bit_next   = '0;
         baud_next  = '0;
`ifdef UART_TX_PARITY_EN
         parity_next = ^mem[head];
`endif
      end else if (state != IDLE) begin
         baud_next = baud_done ? '0 : baud_cnt + 1'b1;
         if (state == START && baud_done) bit_next = '0;
         if (state == DATA && baud_done) begin
            shift_next = {1'b0, shift[7:1]};
            bit_next   = bit_idx + 1'b1;
         end
      end
      case (state_next)
         IDLE:   txd_next = 1'b1;
         START:  txd_next = 1'b0;
         DATA:   txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY: txd_next = parity_next;
`endif
         STOP:   txd_next = 1'b1;
         default: txd_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         shift    <= '0;
         bit_idx  <= '0;
         baud_cnt <= '0;
         txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         shift    <= shift_next;
         bit_idx  <= bit_next;
         baud_cnt <= baud_next;
         txd_q    <= txd_next;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_next;
`endif
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= wr_data;
   end

endmodule
